cpu_trace_capture: RTL and testbench
====================================

// Module: cpu_trace_capture
// PURPOSE
// - Synthesisable instruction-trace capture unit for the simple_cpu family. It takes the place of console monitoring on hardware.
// - Records {PC, instruction, ACC} for each retired instruction into a circular buffer.
// - Stops on a PC breakpoint after a programmable post-trigger count, then raises halt_req.
// - Sits beside the CPU core; fed from its debug outputs; read out by a host/UART bridge.
// PARAMETERS
// - PC_W     8   PC width
// - ACC_W    8   accumulator width
// - INSTR_W  16  instruction width
// - DEPTH    16  buffer entries; power of 2, >=2
// - CNT_W    16  cycle-counter width
// - REC_W = PC_W+INSTR_W+ACC_W (derived; default 32)
// PORTS
// - Interface: one clock; reset is synchronous and active-high.
// - clk_50mhz    in   1                  system clock; all logic on rising edge
// - rst          in   1                  synchronous active-high reset
// - instr_valid  in   1                  one-cycle pulse per retired instruction
// - pc_in        in   PC_W               PC of retiring instruction
// - instr_in     in   INSTR_W            retiring instruction word
// - acc_in       in   ACC_W              ACC after retirement
// - arm          in   1                  pulse: clear buffer, start capture
// - bp_en        in   1                  breakpoint enable
// - bp_addr      in   PC_W               breakpoint PC
// - post_count   in   8                  records kept after the trigger record; sampled on arm
// - rd_en        in   1                  pop oldest record (DONE only)
// - rd_data      out  REC_W(+CNT_W)      popped record {pc,instr,acc[,stamp]}
// - rd_valid     out  1                  rd_data valid, one-cycle pulse
// - rd_empty     out  1                  no records held
// - state_out    out  2                  0 IDLE, 1 ARMED, 2 POST, 3 DONE
// - overflow     out  1                  sticky: an unread record was overwritten
// - halt_req     out  1                  CPU halt request
// - cycle_cnt    out  CNT_W              clocks since arm; saturates at all-ones
// BEHAVIOUR
// - Reset: IDLE; wr_ptr=rd_ptr=count=0; rd_data=0; rd_valid=0; rd_empty=1.
//   Reset also clears overflow, halt_req and cycle_cnt. Reset mid-capture discards all records.
// - IDLE: instr_valid is ignored. arm -> ARMED.
// - ARMED: each instr_valid writes its record at wr_ptr, then wr_ptr++ (mod DEPTH).
//   If count==DEPTH, the write overwrites the oldest record: rd_ptr++, overflow<=1. Otherwise count++.
// - Trigger: instr_valid && bp_en && pc_in==bp_addr while ARMED.
//   The trigger record is written. remaining<=post_count. Next state is POST, or DONE if post_count==0.
// - POST: each instr_valid writes a record (same wrap rules) and remaining--.
//   The write that brings remaining to 0 moves the block to DONE in the same cycle. Further breakpoint hits are treated as plain records.
// - DONE: halt_req=1. Writes are ignored.
//   rd_en && count>0: rd_data<=mem[rd_ptr], rd_valid=1 next cycle, rd_ptr++, count--.
//   rd_en when count==0 is ignored (rd_valid=0). rd_en outside DONE is ignored.
// - rd_empty = (count==0), combinational from count.
// - arm in any state clears the pointers, count, overflow, halt_req and cycle_cnt, then enters ARMED.
//   arm coincident with instr_valid: arm wins and that record is dropped.
// - cycle_cnt: 0 on arm. +1 per clock in ARMED/POST. Held in IDLE/DONE. Saturating.
// - Memory: DEPTH x REC_W register array, no reset on contents. Pointers are log2(DEPTH) bits with natural wrap.
// CONFIGURATION
// - TRACE_CYCLE_STAMP_EN defined: each record gets a low field holding cycle_cnt at write time, so rd_data = {pc,instr,acc,stamp}.
// - TRACE_CYCLE_STAMP_EN undefined: there is no stamp field and rd_data is REC_W bits wide. All other behaviour is identical.
// TESTING
// - rst held 3 clk, then released -> state_out=0, rd_empty=1, halt_req=0, overflow=0.
// - arm; bp_addr=8'h05, bp_en=1, post_count=2; PCs 00..07 retire -> DONE after PC 07; 8 records.
//   Pops return PCs 00..07 in order; rd_empty=1 after the 8th pop; halt_req=1.
// - DEPTH=16, bp_en=0, 20 retires PC 00..13 -> overflow=1 and count=16.
//   Then force bp at PC 14 with post_count=0 -> DONE; first pop is PC 05, last is PC 14.
// - post_count=0, trigger at PC 0A -> DONE in the same cycle; last record popped is PC 0A.
//   rd_en on an empty buffer -> rd_valid stays 0.
// - arm asserted together with instr_valid in ARMED -> record dropped, count=0, cycle_cnt=0. rst pulse in POST -> IDLE, all cleared.
// - With TRACE_CYCLE_STAMP_EN, retires at clocks 3 and 7 after arm -> stamp fields 3 and 7. Without it, rd_data is 32 bits.

Source files
------------

// File: rtl/cpu_trace_capture.sv
// rtl/cpu_trace_capture.sv - circular instruction-trace buffer with PC breakpoint and post-trigger stop
// Define TRACE_CYCLE_STAMP_EN to append a cycle_cnt stamp as the low field of each record.
module cpu_trace_capture #(
  parameter int PC_W    = 8,
  parameter int ACC_W   = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  localparam int REC_W  = PC_W + INSTR_W + ACC_W,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int OUT_W  = REC_W + CNT_W
`else
  localparam int OUT_W  = REC_W
`endif
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic               arm,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [7:0]         post_count,
  input  logic               rd_en,
  output logic [OUT_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_empty,
  output logic [1:0]         state_out,
  output logic               overflow,
  output logic               halt_req,
  output logic [CNT_W-1:0]   cycle_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         remaining_q, remaining_d, post_q, post_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [OUT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_en;
  logic               trigger;
  logic [OUT_W-1:0]   rec_w;
  logic [OUT_W-1:0]   mem_q [DEPTH];

  assign trigger = bp_en && (pc_in == bp_addr);
`ifdef TRACE_CYCLE_STAMP_EN
  assign rec_w = {pc_in, instr_in, acc_in, cycle_q};
`else
  assign rec_w = {pc_in, instr_in, acc_in};
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    post_d      = post_q;
    overflow_d  = overflow_q;
    cycle_d     = cycle_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_en       = 1'b0;
    // arm restarts capture from any state and swallows a coincident retire
    if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      cycle_d    = '0;
      post_d     = post_count;
    end else begin
      if ((state_q == S_ARMED || state_q == S_POST) && cycle_q != '1) cycle_d = cycle_q + 1'b1;
      case (state_q)
        S_ARMED: if (instr_valid) begin
          wr_en = 1'b1;
          if (trigger) begin
            remaining_d = post_q;
            state_d     = (post_q == 8'd0) ? S_DONE : S_POST;
          end
        end
        S_POST: if (instr_valid) begin
          wr_en       = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = S_DONE;
        end
        S_DONE: if (rd_en && count_q != '0) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          count_d    = count_q - 1'b1;
        end
        default: ;
      endcase
      // a full buffer drops its oldest entry to make room
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == FULL) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      post_q      <= '0;
      overflow_q  <= 1'b0;
      cycle_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      post_q      <= post_d;
      overflow_q  <= overflow_d;
      cycle_q     <= cycle_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= rec_w;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_empty  = (count_q == '0);
  assign state_out = state_q;
  assign overflow  = overflow_q;
  assign halt_req  = (state_q == S_DONE);
  assign cycle_cnt = cycle_q;
endmodule

// File: tb/tb_cpu_trace_capture.sv
// tb/tb_cpu_trace_capture.sv - directed self-checking bench for cpu_trace_capture
module tb_cpu_trace_capture;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int OUT_W = 48;
`else
  localparam int OUT_W = 32;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic [7:0]       pc_in = '0;
  logic [15:0]      instr_in = '0;
  logic [7:0]       acc_in = '0;
  logic             arm = 1'b0;
  logic             bp_en = 1'b0;
  logic [7:0]       bp_addr = '0;
  logic [7:0]       post_count = '0;
  logic             rd_en = 1'b0;
  logic [OUT_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_empty;
  logic [1:0]       state_out;
  logic             overflow;
  logic             halt_req;
  logic [15:0]      cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_trace_capture dut (
    .clk_50mhz(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in),
    .instr_in(instr_in), .acc_in(acc_in), .arm(arm), .bp_en(bp_en),
    .bp_addr(bp_addr), .post_count(post_count), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .state_out(state_out), .overflow(overflow), .halt_req(halt_req),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rec(input logic [7:0] pc);
    return {pc, pc, ~pc, pc ^ 8'h5A};
  endfunction

  task automatic retire(input logic [7:0] pc);
    instr_valid = 1'b1;
    pc_in       = pc;
    instr_in    = {pc, ~pc};
    acc_in      = pc ^ 8'h5A;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] post);
    arm        = 1'b1;
    post_count = post;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] pc);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data[OUT_W-1 -: 32]), 64'(rec(pc)));
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_empty", 64'(rd_empty), 64'd1);
    check("rst_halt", 64'(halt_req), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_rdv", 64'(rd_valid), 64'd0);
    check("rst_rdd", 64'(rd_data), 64'd0);
    check("rst_cyc", 64'(cycle_cnt), 64'd0);

    // IDLE ignores retires
    retire(8'h77);
    check("idle_empty", 64'(rd_empty), 64'd1);

    // breakpoint at 05 with two post-trigger records
    bp_en = 1'b1; bp_addr = 8'h05;
    do_arm(8'd2);
    check("arm_state", 64'(state_out), 64'd1);
    for (int i = 0; i < 8; i++) begin
      retire(8'(i));
      if (i == 5) check("trig_post", 64'(state_out), 64'd2);
    end
    check("bp_done", 64'(state_out), 64'd3);
    check("bp_halt", 64'(halt_req), 64'd1);
    check("bp_cyc", 64'(cycle_cnt), 64'd8);
    retire(8'h08);
    for (int i = 0; i < 8; i++) pop($sformatf("bp_pop%0d", i), 8'(i));
    check("bp_empty", 64'(rd_empty), 64'd1);
    check("bp_halt2", 64'(halt_req), 64'd1);
    check("bp_cyc_hold", 64'(cycle_cnt), 64'd8);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("bp_rd_empty", 64'(rd_valid), 64'd0);

    // overflow: 21 records into 16 entries
    bp_en = 1'b0;
    do_arm(8'd0);
    check("ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 20; i++) retire(8'(i));
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_armed", 64'(state_out), 64'd1);
    bp_en = 1'b1; bp_addr = 8'h14;
    retire(8'h14);
    check("ovf_done", 64'(state_out), 64'd3);
    for (int i = 0; i < 16; i++) pop($sformatf("ovf_pop%0d", i), 8'(i + 5));
    check("ovf_empty", 64'(rd_empty), 64'd1);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // post_count 0: DONE on the trigger record itself
    bp_addr = 8'h0A;
    do_arm(8'd0);
    retire(8'h08);
    retire(8'h09);
    check("p0_armed", 64'(state_out), 64'd1);
    retire(8'h0A);
    check("p0_done", 64'(state_out), 64'd3);
    pop("p0_pop0", 8'h08);
    pop("p0_pop1", 8'h09);
    pop("p0_pop2", 8'h0A);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("p0_rd_empty", 64'(rd_valid), 64'd0);

    // arm coincident with retire drops the record
    bp_en = 1'b0;
    do_arm(8'd3);
    retire(8'h01);
    retire(8'h02);
    arm = 1'b1; instr_valid = 1'b1; pc_in = 8'h33;
    tick();
    arm = 1'b0; instr_valid = 1'b0;
    check("coin_state", 64'(state_out), 64'd1);
    check("coin_empty", 64'(rd_empty), 64'd1);
    check("coin_cyc", 64'(cycle_cnt), 64'd0);
    retire(8'h40);
    bp_en = 1'b1; bp_addr = 8'h41;
    retire(8'h41);
    check("coin_post", 64'(state_out), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_state", 64'(state_out), 64'd0);
    check("mid_rst_empty", 64'(rd_empty), 64'd1);
    check("mid_rst_halt", 64'(halt_req), 64'd0);
    check("mid_rst_cyc", 64'(cycle_cnt), 64'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("idle_rd", 64'(rd_valid), 64'd0);

    // retires sampled when cycle_cnt reads 3 and 7
    bp_en = 1'b0;
    do_arm(8'd0);
    repeat (3) tick();
    retire(8'h61);
    repeat (3) tick();
    bp_en = 1'b1; bp_addr = 8'h62;
    retire(8'h62);
    check("st_done", 64'(state_out), 64'd3);
    check("st_cyc", 64'(cycle_cnt), 64'd8);
    pop("st_pop0", 8'h61);
`ifdef TRACE_CYCLE_STAMP_EN
    check("st_stamp0", 64'(rd_data[15:0]), 64'd3);
`endif
    pop("st_pop1", 8'h62);
`ifdef TRACE_CYCLE_STAMP_EN
    check("st_stamp1", 64'(rd_data[15:0]), 64'd7);
`endif
    check("st_empty", 64'(rd_empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
